// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Direct-mapped, write-back, write-allocate data cache controller.
//            Hits complete in the request cycle. A miss stalls the CPU while
//            the FSM writes back a dirty victim line (WBACK) and refills the
//            line (ALLOC) over a req/ack memory handshake.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            cpu_valid_i/we_i   - CPU access request / store select
//            cpu_addr_i/wdata_i - CPU byte address / store data
//            cpu_rdata_o        - load data (combinational)
//            stall_o            - CPU must hold its request while high
//            mem_req_o/we_o     - memory request / write-back select
//            mem_addr_o         - line-aligned memory byte address
//            mem_wdata_o        - victim line data
//            mem_rdata_i/ack_i  - fill line data / one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cpu_valid_i,
    input  logic                         cpu_we_i,
    input  logic [31:0]                  cpu_addr_i,
    input  logic [31:0]                  cpu_wdata_i,
    output logic [31:0]                  cpu_rdata_o,
    output logic                         stall_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [31:0]                  mem_addr_o,
    output logic [32*WORDS_PER_LINE-1:0] mem_wdata_o,
    input  logic [32*WORDS_PER_LINE-1:0] mem_rdata_i,
    input  logic                         mem_ack_i
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 32 - IDX_W - OFF_W - 2;
    localparam int LINE_W = 32 * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WBACK  = 2'd1,
        S_ALLOC  = 2'd2,
        S_REFILL = 2'd3
    } state_t;

    // Address decomposition of the live CPU request
    logic [OFF_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_unused_addr;

    assign w_off         = cpu_addr_i[OFF_W+1:2];
    assign w_idx         = cpu_addr_i[OFF_W+2 +: IDX_W];
    assign w_tag         = cpu_addr_i[31 -: TAG_W];
    assign w_unused_addr = ^cpu_addr_i[1:0];

    // Line storage: valid/dirty in resettable flops, tag/data unreset
    logic [LINES-1:0]                     valid_q;
    logic [LINES-1:0]                     dirty_q;
    logic [TAG_W-1:0]                     tag_q  [LINES];
    logic [WORDS_PER_LINE-1:0][31:0]      data_q [LINES];

    state_t           state_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    // Missing line is captured so the refill completes even if the CPU
    // drops cpu_valid_i mid-miss.
    logic [TAG_W-1:0] miss_tag_q;
    logic [IDX_W-1:0] miss_idx_q;

    logic w_hit;
    logic w_store_hit;
    logic w_refill;

    assign w_hit       = cpu_valid_i & valid_q[w_idx] & (tag_q[w_idx] == w_tag);
    assign w_store_hit = (state_q == S_IDLE) & w_hit & cpu_we_i;
    assign w_refill    = (state_q == S_ALLOC) & mem_ack_i;

    // rst_n gate keeps stall low while in reset even though all lines read
    // as invalid (which would otherwise look like a miss).
    assign stall_o     = rst_n & cpu_valid_i & ((state_q != S_IDLE) | ~w_hit);
    assign cpu_rdata_o = data_q[w_idx][w_off];

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

    // Tag/data arrays: refill overwrites the whole line, store hit one word
    always_ff @(posedge clk) begin
        if (w_refill) begin
            data_q[miss_idx_q] <= mem_rdata_i;
            tag_q[miss_idx_q]  <= miss_tag_q;
        end else if (w_store_hit) begin
            data_q[w_idx][w_off] <= cpu_wdata_i;
        end
    end

    // Miss FSM with registered memory-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cpu_valid_i && !w_hit) begin
                        miss_tag_q <= w_tag;
                        miss_idx_q <= w_idx;
                        mem_req_q  <= 1'b1;
                        if (valid_q[w_idx] && dirty_q[w_idx]) begin
                            state_q     <= S_WBACK;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[w_idx], w_idx, {(OFF_W+2){1'b0}}};
                            mem_wdata_q <= data_q[w_idx];
                        end else begin
                            state_q    <= S_ALLOC;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {w_tag, w_idx, {(OFF_W+2){1'b0}}};
                        end
                    end else if (w_store_hit) begin
                        dirty_q[w_idx] <= 1'b1;
                    end
                end
                S_WBACK: begin
                    // Fill request follows the write-back without a gap
                    if (mem_ack_i) begin
                        state_q    <= S_ALLOC;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {miss_tag_q, miss_idx_q, {(OFF_W+2){1'b0}}};
                    end
                end
                S_ALLOC: begin
                    if (mem_ack_i) begin
                        state_q             <= S_REFILL;
                        mem_req_q           <= 1'b0;
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                    end
                end
                S_REFILL: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Purpose  : Directed self-checking bench for dcache_ctrl (LINES=64,
//            WORDS_PER_LINE=4). Memory responses are driven by hand; fill
//            word k of line address A is 32'hC0DE0000 + A + k.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic         clk;
    logic         rst_n;
    logic         cpu_valid;
    logic         cpu_we;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         stall;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;

    int checks = 0;
    int errors = 0;

    dcache_ctrl #(
        .LINES          (64),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_valid_i (cpu_valid),
        .cpu_we_i    (cpu_we),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .stall_o     (stall),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] pat(input logic [31:0] a);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = 32'hC0DE0000 + a + k;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the cycle before the memory request appears. Checks the
    // request is held for 'delay' cycles, then acks it with pat(a).
    task automatic serve(input int delay, input logic [31:0] a, input logic we,
                         input logic [127:0] wd);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk); #1;
            chk("hold_req",   mem_req,  1'b1);
            chk("hold_addr",  mem_addr, a);
            chk("hold_we",    mem_we,   we);
            chk("hold_stall", stall,    1'b1);
            if (we) chk("hold_wdata", mem_wdata, wd);
        end
        @(negedge clk);
        mem_rdata = pat(a);
        mem_ack   = 1'b1;
        #1;
        chk("ack_req",   mem_req,  1'b1);
        chk("ack_addr",  mem_addr, a);
        chk("ack_we",    mem_we,   we);
        chk("ack_stall", stall,    1'b1);
        if (we) chk("ack_wdata", mem_wdata, wd);
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    // One REFILL_DONE stall cycle, then the held access must hit
    task automatic finish_miss(input logic [31:0] exp_rdata, input logic is_load);
        @(negedge clk); #1;
        chk("refill_stall", stall,   1'b1);
        chk("refill_req",   mem_req, 1'b0);
        @(negedge clk); #1;
        chk("hit_stall", stall, 1'b0);
        if (is_load) chk("hit_rdata", cpu_rdata, exp_rdata);
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] a,
                         input logic [31:0] wd);
        cpu_valid = v;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = wd;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall",   stall,    1'b0);
        chk("rst_req",     mem_req,  1'b0);
        chk("rst_we",      mem_we,   1'b0);
        chk("rst_addr",    mem_addr, 32'h0);
        cpu_valid = 1'b1;
        #1;
        chk("rst_stall_valid", stall, 1'b0);
        cpu_valid = 1'b0;

        // 1: cold store miss, refill, store merge, then load hit
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 32'h0000_0010, 32'hDEADBEEF);
        #1;
        chk("t1_stall", stall,   1'b1);
        chk("t1_req0",  mem_req, 1'b0);
        serve(0, 32'h0000_0010, 1'b0, '0);
        finish_miss(32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        #1;
        chk("t1_load_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("t1_load_stall", stall,     1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0014, 32'h0);
        #1;
        chk("t1_word1", cpu_rdata, 32'hC0DE0011);

        // 2: dirty eviction -> write-back of merged line, then fill
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0410, 32'h0);
        #1;
        chk("t2_stall", stall, 1'b1);
        serve(0, 32'h0000_0010, 1'b1, 128'hC0DE0013_C0DE0012_C0DE0011_DEADBEEF);
        serve(0, 32'h0000_0410, 1'b0, '0);
        finish_miss(32'hC0DE0410, 1'b1);

        // 3: clean eviction -> straight to fill, no write-back
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0810, 32'h0);
        #1;
        chk("t3_stall", stall, 1'b1);
        serve(2, 32'h0000_0810, 1'b0, '0);
        finish_miss(32'hC0DE0810, 1'b1);

        // 4: ack delayed 7 cycles, request held stable
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0018, 32'h0);
        #1;
        chk("t4_stall", stall, 1'b1);
        serve(7, 32'h0000_0010, 1'b0, '0);
        finish_miss(32'hC0DE0012, 1'b1);

        // Make the line dirty again for the reset test
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h0000_0014, 32'h12345678);
        #1;
        chk("t4_store_stall", stall, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0014, 32'h0);
        #1;
        chk("t4_store_rdata", cpu_rdata, 32'h12345678);

        // 5: reset asserted during WBACK aborts the request
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0000_0410, 32'h0);
        #1;
        chk("t5_stall", stall, 1'b1);
        @(negedge clk); #1;
        chk("t5_wback_req", mem_req, 1'b1);
        chk("t5_wback_we",  mem_we,  1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req",   mem_req, 1'b0);
        chk("t5_rst_stall", stall,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        #1;
        chk("t5_post_miss", stall, 1'b1);
        serve(0, 32'h0000_0010, 1'b0, '0);
        finish_miss(32'hC0DE0010, 1'b1);

        // 6: back-to-back hits on all four words
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 32'h0000_0010 + 32'(4 * k), 32'h0);
            #1;
            chk("t6_stall", stall,     1'b0);
            chk("t6_rdata", cpu_rdata, 32'hC0DE0010 + 32'(k));
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0000_0410, 32'h0);
        #1;
        chk("t6_idle_stall", stall, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
